// File: rtl/npc_pkg.sv
// -----------------------------------------------------------------------------
// npc_pkg
// Shared definitions for the NPC core front end.
//   XLEN              : architectural register / address width
//   RESET_PC_DEFAULT  : PC loaded on reset unless overridden
//   ifu_state_t       : instruction fetch unit state encoding
//   pc_misaligned()   : true when a target PC is not word aligned
// -----------------------------------------------------------------------------
package npc_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;

    typedef enum logic [2:0] {
        ST_REQ      = 3'd0,
        ST_WAIT_RSP = 3'd1,
        ST_HOLD     = 3'd2,
        ST_WAIT_NPC = 3'd3,
        ST_HALT     = 3'd4
    } ifu_state_t;

    // Instructions are 32-bit and word aligned; any low address bit set is a fault.
    function automatic logic pc_misaligned(input logic [XLEN-1:0] addr);
        pc_misaligned = (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/ifu_if.sv
// -----------------------------------------------------------------------------
// ifu_if
// Bundles the fetch unit's two handshake channels:
//   imem_req_* / imem_rsp_* : instruction memory request and read response
//   inst_* / pc             : held instruction offered to execute
//   npc_valid / dnpc / is_ebreak : completion report from execute
// Modports:
//   master : the fetch unit side
//   slave  : the memory + execute side
// -----------------------------------------------------------------------------
interface ifu_if;
    import npc_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;

    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;

    logic            npc_valid;
    logic [XLEN-1:0] dnpc;
    logic            is_ebreak;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data,
        output inst_valid, inst, pc,
        input  inst_ready,
        input  npc_valid, dnpc, is_ebreak
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data,
        input  inst_valid, inst, pc,
        output inst_ready,
        output npc_valid, dnpc, is_ebreak
    );

endinterface

// File: rtl/ifu.sv
// -----------------------------------------------------------------------------
// ifu
// Non-pipelined instruction fetch unit: owns the PC, issues one memory read per
// instruction, holds the returned word for execute and waits for execute to
// report the next PC before fetching again. Exactly one instruction in flight.
// Ports:
//   clk, rst_n  : clock (rising edge) and asynchronous active-low reset
//   bus         : ifu_if.master (memory request/response, instruction, next PC)
//   halted      : core stopped (ebreak or misaligned next PC)
//   fault       : stop was caused by a misaligned next PC
//   retire_cnt  : count of completed instructions, wraps at 2^64
// -----------------------------------------------------------------------------
module ifu
    import npc_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    ifu_if.master       bus,
    output logic        halted,
    output logic        fault,
    output logic [63:0] retire_cnt
);

    ifu_state_t      r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_inst;
    logic            r_halted;
    logic            r_fault;
    logic [63:0]     r_retire_cnt;

    logic            w_resolve;

    // NPC is resolved either in the consume cycle of HOLD (npc already present)
    // or later from WAIT_NPC; any other npc_valid is ignored.
    always_comb begin
        w_resolve = 1'b0;
        if ((r_state == ST_HOLD) && bus.inst_ready && bus.npc_valid) begin
            w_resolve = 1'b1;
        end else if ((r_state == ST_WAIT_NPC) && bus.npc_valid) begin
            w_resolve = 1'b1;
        end else begin
            w_resolve = 1'b0;
        end
    end

    // Fetch control FSM, PC, held instruction, halt/fault flags and retire counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_REQ;
            r_pc         <= RESET_PC;
            r_inst       <= 32'h0000_0000;
            r_halted     <= 1'b0;
            r_fault      <= 1'b0;
            r_retire_cnt <= 64'd0;
        end else begin
            case (r_state)
                ST_REQ: begin
                    if (bus.imem_req_ready) begin
                        r_state <= ST_WAIT_RSP;
                    end else begin
                        r_state <= ST_REQ;
                    end
                end
                ST_WAIT_RSP: begin
                    // The response can only be taken here, so it is never
                    // accepted in the same cycle as its request handshake.
                    if (bus.imem_rsp_valid) begin
                        r_inst  <= bus.imem_rsp_data;
                        r_state <= ST_HOLD;
                    end else begin
                        r_state <= ST_WAIT_RSP;
                    end
                end
                ST_HOLD: begin
                    if (bus.inst_ready && !bus.npc_valid) begin
                        r_state <= ST_WAIT_NPC;
                    end else begin
                        r_state <= ST_HOLD;
                    end
                end
                ST_WAIT_NPC: begin
                    r_state <= ST_WAIT_NPC;
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    // Unreachable encodings stop the core rather than fetch.
                    r_state  <= ST_HALT;
                    r_halted <= 1'b1;
                end
            endcase

            // Resolution overrides the hold-in-place transitions above.
            if (w_resolve) begin
                r_retire_cnt <= r_retire_cnt + 64'd1;
                if (bus.is_ebreak) begin
                    r_state  <= ST_HALT;
                    r_halted <= 1'b1;
                end else if (pc_misaligned(bus.dnpc)) begin
                    // PC is left pointing at the instruction that jumped badly.
                    r_state  <= ST_HALT;
                    r_halted <= 1'b1;
                    r_fault  <= 1'b1;
                end else begin
                    r_pc    <= bus.dnpc;
                    r_state <= ST_REQ;
                end
            end else begin
                r_retire_cnt <= r_retire_cnt;
            end
        end
    end

    // Request and instruction valids are pure state decodes: no path from
    // imem_rsp_* to inst_* and none from npc_valid to imem_req_*.
    assign bus.imem_req_valid = (r_state == ST_REQ);
    assign bus.imem_req_addr  = r_pc;
    assign bus.inst_valid     = (r_state == ST_HOLD);
    assign bus.inst           = r_inst;
    assign bus.pc             = r_pc;

    assign halted     = r_halted;
    assign fault      = r_fault;
    assign retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_ifu.sv
// -----------------------------------------------------------------------------
// tb_ifu
// Directed bench for the instruction fetch unit. Inputs are driven and outputs
// sampled on the falling edge; the DUT updates on the rising edge.
// -----------------------------------------------------------------------------
module tb_ifu;
    import npc_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        halted;
    logic        fault;
    logic [63:0] retire_cnt;

    int checks;
    int errors;

    ifu_if bus ();

    ifu #(.RESET_PC(32'h8000_0000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.master),
        .halted     (halted),
        .fault      (fault),
        .retire_cnt (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0000_0000;
        bus.inst_ready     = 1'b0;
        bus.npc_valid      = 1'b0;
        bus.dnpc           = 32'h0000_0000;
        bus.is_ebreak      = 1'b0;
    endtask

    // Called on a falling edge while the DUT sits in REQ at 'addr'; takes the
    // handshake and returns 'data', ending on the falling edge in HOLD.
    task automatic fetch(input logic [31:0] addr, input logic [31:0] data);
        checks++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== addr) begin
            errors++;
            $display("FAIL fetch_req: valid=%b addr=%h, required valid=1 addr=%h",
                     bus.imem_req_valid, bus.imem_req_addr, addr);
        end
        bus.imem_req_ready = 1'b1;
        step();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = data;
        checks++;
        if (bus.imem_req_valid !== 1'b0 || bus.inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL fetch_wait_rsp: req_valid=%b inst_valid=%b, required 0/0",
                     bus.imem_req_valid, bus.inst_valid);
        end
        step();
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0000_0000;
        checks++;
        if (bus.inst_valid !== 1'b1 || bus.inst !== data || bus.pc !== addr) begin
            errors++;
            $display("FAIL fetch_hold: inst_valid=%b inst=%h pc=%h, required 1 %h %h",
                     bus.inst_valid, bus.inst, bus.pc, data, addr);
        end
    endtask

    // Consume with npc in the same cycle; ends on the falling edge after resolve.
    task automatic consume_now(input logic [31:0] npc, input logic ebreak);
        bus.inst_ready = 1'b1;
        bus.npc_valid  = 1'b1;
        bus.dnpc       = npc;
        bus.is_ebreak  = ebreak;
        step();
        bus.inst_ready = 1'b0;
        bus.npc_valid  = 1'b0;
        bus.is_ebreak  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        checks++;
        if (bus.pc !== 32'h8000_0000 || bus.inst !== 32'h0 || bus.inst_valid !== 1'b0 ||
            halted !== 1'b0 || fault !== 1'b0 || retire_cnt !== 64'd0) begin
            errors++;
            $display("FAIL reset_values: pc=%h inst=%h iv=%b halted=%b fault=%b retire=%0d, required 80000000 0 0 0 0 0",
                     bus.pc, bus.inst, bus.inst_valid, halted, fault, retire_cnt);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h8000_0000) begin
            errors++;
            $display("FAIL reset_first_req: valid=%b addr=%h, required 1 80000000",
                     bus.imem_req_valid, bus.imem_req_addr);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] addr;
        addr = 32'h8000_0000;
        for (int i = 0; i < 3; i++) begin
            // Three falling edges per instruction: REQ, WAIT_RSP, HOLD.
            fetch(addr, 32'h0000_0013);
            consume_now(addr + 32'd4, 1'b0);
            addr = addr + 32'd4;
        end
        checks++;
        if (retire_cnt !== 64'd3 || bus.imem_req_addr !== 32'h8000_000C || bus.imem_req_valid !== 1'b1) begin
            errors++;
            $display("FAIL seq_retire: retire=%0d addr=%h valid=%b, required 3 8000000c 1",
                     retire_cnt, bus.imem_req_addr, bus.imem_req_valid);
        end
    endtask

    task automatic test_req_stall();
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h8000_000C) begin
                errors++;
                $display("FAIL req_stall_%0d: valid=%b addr=%h, required 1 8000000c",
                         i, bus.imem_req_valid, bus.imem_req_addr);
            end
        end
        fetch(32'h8000_000C, 32'h0040_0113);
        consume_now(32'h8000_0010, 1'b0);
        checks++;
        if (retire_cnt !== 64'd4 || bus.imem_req_addr !== 32'h8000_0010) begin
            errors++;
            $display("FAIL req_stall_done: retire=%0d addr=%h, required 4 80000010",
                     retire_cnt, bus.imem_req_addr);
        end
    endtask

    task automatic test_hold_stall();
        fetch(32'h8000_0010, 32'h0010_0093);
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (bus.inst_valid !== 1'b1 || bus.inst !== 32'h0010_0093 || bus.pc !== 32'h8000_0010) begin
                errors++;
                $display("FAIL hold_stall_%0d: iv=%b inst=%h pc=%h, required 1 00100093 80000010",
                         i, bus.inst_valid, bus.inst, bus.pc);
            end
        end
        bus.inst_ready = 1'b1;
        step();
        bus.inst_ready = 1'b0;
        checks++;
        if (bus.inst_valid !== 1'b0 || bus.imem_req_valid !== 1'b0 || retire_cnt !== 64'd4) begin
            errors++;
            $display("FAIL wait_npc: iv=%b req_valid=%b retire=%0d, required 0 0 4",
                     bus.inst_valid, bus.imem_req_valid, retire_cnt);
        end
        step();
        bus.npc_valid = 1'b1;
        bus.dnpc      = 32'h8000_0100;
        step();
        bus.npc_valid = 1'b0;
        checks++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h8000_0100 || retire_cnt !== 64'd5) begin
            errors++;
            $display("FAIL late_npc: valid=%b addr=%h retire=%0d, required 1 80000100 5",
                     bus.imem_req_valid, bus.imem_req_addr, retire_cnt);
        end
    endtask

    task automatic test_spurious();
        bus.npc_valid      = 1'b1;
        bus.dnpc           = 32'h0000_1234;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'hDEAD_BEEF;
        step();
        idle_inputs();
        checks++;
        if (bus.imem_req_valid !== 1'b1 || bus.pc !== 32'h8000_0100 || retire_cnt !== 64'd5 ||
            bus.inst !== 32'h0010_0093) begin
            errors++;
            $display("FAIL spurious_in_req: valid=%b pc=%h retire=%0d inst=%h, required 1 80000100 5 00100093",
                     bus.imem_req_valid, bus.pc, retire_cnt, bus.inst);
        end
    endtask

    task automatic test_ebreak();
        fetch(32'h8000_0100, 32'h0010_0073);
        consume_now(32'h8000_0104, 1'b1);
        checks++;
        if (halted !== 1'b1 || fault !== 1'b0 || retire_cnt !== 64'd6 || bus.pc !== 32'h8000_0100) begin
            errors++;
            $display("FAIL ebreak_halt: halted=%b fault=%b retire=%0d pc=%h, required 1 0 6 80000100",
                     halted, fault, retire_cnt, bus.pc);
        end
        bus.imem_req_ready = 1'b1;
        bus.npc_valid      = 1'b1;
        bus.dnpc           = 32'h8000_0200;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.imem_req_valid !== 1'b0 || bus.inst_valid !== 1'b0 || retire_cnt !== 64'd6) begin
                errors++;
                $display("FAIL halt_quiet_%0d: req_valid=%b iv=%b retire=%0d, required 0 0 6",
                         i, bus.imem_req_valid, bus.inst_valid, retire_cnt);
            end
        end
        idle_inputs();
    endtask

    task automatic test_fault();
        do_reset();
        step();
        checks++;
        if (halted !== 1'b0 || retire_cnt !== 64'd0 || bus.pc !== 32'h8000_0000) begin
            errors++;
            $display("FAIL fault_reset: halted=%b retire=%0d pc=%h, required 0 0 80000000",
                     halted, retire_cnt, bus.pc);
        end
        fetch(32'h8000_0000, 32'h0000_0013);
        consume_now(32'h8000_0102, 1'b0);
        checks++;
        if (halted !== 1'b1 || fault !== 1'b1 || bus.pc !== 32'h8000_0000 ||
            retire_cnt !== 64'd1 || bus.imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL misaligned: halted=%b fault=%b pc=%h retire=%0d req_valid=%b, required 1 1 80000000 1 0",
                     halted, fault, bus.pc, retire_cnt, bus.imem_req_valid);
        end
    endtask

    task automatic test_reset_wait_rsp();
        do_reset();
        step();
        bus.imem_req_ready = 1'b1;
        step();
        bus.imem_req_ready = 1'b0;
        // In WAIT_RSP now; reset mid-flight, then the stale response shows up.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'hDEAD_BEEF;
        step();
        bus.imem_rsp_valid = 1'b0;
        checks++;
        if (bus.inst_valid !== 1'b0 || bus.inst !== 32'h0 || bus.imem_req_valid !== 1'b1 ||
            bus.imem_req_addr !== 32'h8000_0000 || halted !== 1'b0 || fault !== 1'b0) begin
            errors++;
            $display("FAIL stale_rsp: iv=%b inst=%h req_valid=%b addr=%h halted=%b fault=%b, required 0 0 1 80000000 0 0",
                     bus.inst_valid, bus.inst, bus.imem_req_valid, bus.imem_req_addr, halted, fault);
        end
        fetch(32'h8000_0000, 32'h0000_0013);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        idle_inputs();
        test_reset();
        test_sequential();
        test_req_stall();
        test_hold_stall();
        test_spurious();
        test_ebreak();
        test_fault();
        test_reset_wait_rsp();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
